// File: rtl/pc_btb_predictor.sv
// pc_btb_predictor: fetch-stage PC register with a direct-mapped BTB and 2-bit counters.
// Ports: clk/rst_n (async active-low); stall_F, redirect/redirect_pc steer PC_F;
//        upd_valid/upd_pc/upd_taken/upd_target train the BTB; PC_F, pred_taken_F, PC_next out.
// Latency: PC_F registered (redirect visible after one edge); prediction is combinational on PC_F.
// Optional feature macro: PC_BTB_PREDICT_EN. When undefined there is no BTB and prediction
// is static not-taken (PC_next = PC_F + 4), with the upd_* inputs ignored.
module pc_btb_predictor #(
  parameter int              XLEN     = 32,
  parameter int              ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_F,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] PC_F,
  output logic            pred_taken_F,
  output logic [XLEN-1:0] PC_next
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic            pred;
  logic [XLEN-1:0] next_pc;

  // Wraps modulo 2^XLEN naturally.
  assign pc_plus4 = pc_q + XLEN'(4);

`ifdef PC_BTB_PREDICT_EN
  logic             valid_q  [ENTRIES];
  logic [TAGW-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX-1:0]   look_idx;
  logic [TAGW-1:0]  look_tag;
  logic             look_hit;
  logic [IDX-1:0]   upd_idx;
  logic [TAGW-1:0]  upd_tag;
  logic             upd_hit;
  logic [1:0]       unused_upd_lsb;

  assign look_idx = pc_q[IDX+1:2];
  assign look_tag = pc_q[XLEN-1:IDX+2];
  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign pred     = look_hit && ctr_q[look_idx][1];
  assign next_pc  = pred ? target_q[look_idx] : pc_plus4;

  assign upd_idx  = upd_pc[IDX+1:2];
  assign upd_tag  = upd_pc[XLEN-1:IDX+2];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // Instructions are word aligned; the low PC bits carry no BTB information.
  assign unused_upd_lsb = upd_pc[1:0];

  // Training lands at the edge; a same-cycle lookup of the same entry sees old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd1;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'd3) ? 2'd3 : ctr_q[upd_idx] + 2'd1;
          target_q[upd_idx] <= upd_target;
        end else begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'd0) ? 2'd0 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate (or evict an alias) as weakly taken.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'd2;
      end
    end
  end
`else
  logic unused_upd;

  assign pred       = 1'b0;
  assign next_pc    = pc_plus4;
  assign unused_upd = ^{upd_valid, upd_taken, upd_pc, upd_target};
`endif

  // Redirect beats stall; otherwise follow the prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_pc;
    end else if (!stall_F) begin
      pc_q <= next_pc;
    end
  end

  assign PC_F         = pc_q;
  assign pred_taken_F = pred;
  assign PC_next      = next_pc;

endmodule
